kernel_bank_ctrl: RTL
=====================

KERNEL_BANK_CTRL -- requirements
Module: kernel_bank_ctrl

Interface
REQ-001 SHALL have parameter PRECISION, default 16, meaning the signed coefficient width delivered to the stream kernels.
REQ-002 SHALL have parameter COEFF_W, default 4, meaning the signed width of the user coefficient input.
REQ-003 SHALL have port VGA_CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port iVGA_VS, input, 1, the incoming vertical sync (low between frames).
REQ-006 SHALL have port step, input, 1, a one-cycle pulse that advances the edit cursor.
REQ-007 SHALL have port wr_en, input, 1, a one-cycle pulse that writes coeff_in at the cursor.
REQ-008 SHALL have port coeff_in, input, COEFF_W, a signed coefficient.
REQ-009 SHALL have port clear, input, 1, a one-cycle pulse that loads identity into the shadow bank.
REQ-010 SHALL have port commit_req, input, 1, a one-cycle pulse that requests a shadow-to-active swap.
REQ-011 SHALL have port mode_in, input, 4, the requested filter select.
REQ-012 SHALL have port kernel, output, 3x3xPRECISION signed, the active kernel, indexed [row][col].
REQ-013 SHALL have port mode, output, 4, the active filter select.
REQ-014 SHALL have ports cur_x and cur_y, output, 2 each, the cursor column and row.
REQ-015 SHALL have port pending, output, 1, high while a commit awaits a frame boundary.
REQ-016 SHALL have port commit_ack, output, 1, a one-cycle pulse when the active bank updates.
REQ-017 SHALL have port rejected, output, 1, a one-cycle pulse when a write, clear or commit is dropped.

Function
REQ-018 SHALL hold a shadow 3x3 bank plus a shadow mode; only the active bank drives kernel and mode.
REQ-019 SHALL sign-extend coeff_in to PRECISION on write.
REQ-020 SHALL advance the cursor row-major on step: x 0->1->2->0, with y incrementing when x wraps and y wrapping 2->0.
REQ-021 SHALL, when wr_en and step occur in the same cycle, write at the old cursor and then advance.
REQ-022 SHALL give clear priority over wr_en in the same cycle; the cursor is unchanged by clear.
REQ-023 SHALL detect a VS falling edge as vs_d=1 with iVGA_VS=0, where vs_d is iVGA_VS registered.
REQ-024 SHALL implement a state machine with states IDLE, PENDING and SWAP:
- IDLE + commit_req -> PENDING, and mode_in is latched into the shadow mode.
- PENDING + VS fall -> SWAP.
- SWAP -> IDLE after one cycle.
REQ-025 SHALL, on the SWAP clock edge, copy the shadow bank and mode into the active registers and assert commit_ack in the following cycle, in which the new kernel is already visible.
REQ-026 SHALL drive pending high in PENDING and SWAP, and low otherwise.
REQ-027 SHALL, in PENDING or SWAP, drop wr_en, clear and commit_req, pulse rejected the next cycle, and leave the shadow unchanged; step is still honoured.
REQ-028 SHALL ignore a VS fall seen in IDLE.
REQ-029 SHALL make commit_req coincident with a VS fall in IDLE enter PENDING only, so the swap waits for the next frame boundary.
REQ-030 SHALL register all outputs; none is combinationally derived from inputs.

Reset
REQ-031 SHALL, on reset, load the active and shadow banks with identity: [1][1]=1 and all other cells 0.
REQ-032 SHALL, on reset, set mode=0, cur_x=cur_y=0, state=IDLE, vs_d=0, and pending, commit_ack and rejected low.
REQ-033 SHALL, on reset asserted mid-PENDING or mid-SWAP, abandon the swap; the active bank returns to identity.

Structure
REQ-034 SHALL take PRECISION, the kernel dimension 3, the identity kernel constant and the state enum from shared package filter_pkg.
REQ-035 SHALL use one sub-module, vsync_edge, a registered falling-edge detector with synchronous reset.

Verification
REQ-036 SHALL check reset: assert reset for 2 cycles -> kernel[1][1]=1, all other cells 0, mode=0, cursor (0,0), pending=0.
REQ-037 SHALL check cursor wrap: 9 step pulses -> cursor returns to (0,0); 4 steps -> cursor (1,1).
REQ-038 SHALL check commit: write coeff_in=4'b1111 at (0,0), commit_req with mode_in=5, VS high->low 100 cycles later -> kernel[0][0]=16'hFFFF and mode=5 exactly 2 cycles after the edge-detect cycle, commit_ack a single pulse, pending low after.
REQ-039 SHALL check blocking: wr_en while pending -> rejected pulses once, and after the swap kernel[0][0] holds the pre-pending shadow value.
REQ-040 SHALL check simultaneity: wr_en+step at (2,2) -> write lands at [2][2] and cursor becomes (0,0); commit_req on a VS-fall cycle -> swap only on the next VS fall.
REQ-041 SHALL check reset mid-PENDING: reset during PENDING -> identity kernel, no commit_ack on later VS falls.

Source files
------------

// File: rtl/filter_pkg.sv
// filter_pkg: constants and types shared by the kernel bank controller and
// the stream kernels that consume its output.
//   KERNEL_PRECISION - default signed coefficient width seen by the kernels
//   KDIM             - kernel dimension (3x3)
//   IDENTITY_MASK    - cells of the identity kernel that hold 1, indexed [row][col]
//   bank_state_e     - commit handshake states
package filter_pkg;

    localparam int KERNEL_PRECISION = 16;
    localparam int KDIM             = 3;

    // Only the centre tap [1][1] is set (bit 1*3+1 = 4).
    localparam logic [KDIM-1:0][KDIM-1:0] IDENTITY_MASK = 9'b000_010_000;

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWAP
    } bank_state_e;

endpackage

// File: rtl/vsync_edge.sv
// vsync_edge: falling-edge detector for the vertical sync.
//   VGA_CLK - clock (rising edge)
//   reset   - synchronous active-high reset, clears the delayed sample
//   vs      - incoming vertical sync
//   fall    - high in the cycle where the delayed sample is 1 and vs is 0
module vsync_edge (
    input  logic VGA_CLK,
    input  logic reset,
    input  logic vs,
    output logic fall
);

    logic vs_d;

    always_ff @(posedge VGA_CLK) begin
        if (reset) vs_d <= 1'b0;
        else       vs_d <= vs;
    end

    assign fall = vs_d & ~vs;

endmodule

// File: rtl/kernel_bank_ctrl.sv
// kernel_bank_ctrl: double-buffered 3x3 coefficient bank for the stream
// filters. Coefficients are edited in a shadow bank through a cursor, and a
// commit copies shadow bank + mode into the active registers on the next
// vertical-sync falling edge, so a frame never sees a half-updated kernel.
//   VGA_CLK    - clock (rising edge)
//   reset      - synchronous active-high reset
//   iVGA_VS    - vertical sync, low between frames
//   step       - pulse, advance cursor row-major
//   wr_en      - pulse, write sign-extended coeff_in at the cursor
//   coeff_in   - signed COEFF_W coefficient
//   clear      - pulse, load identity into the shadow bank
//   commit_req - pulse, latch mode_in and request a swap at the next frame boundary
//   mode_in    - requested filter select
//   kernel     - active kernel [row][col], PRECISION-bit signed cells
//   mode       - active filter select
//   cur_x/y    - cursor column / row
//   pending    - a commit is waiting for (or performing) the swap
//   commit_ack - pulse, active bank has just been updated
//   rejected   - pulse, a write/clear/commit arrived while busy and was dropped
module kernel_bank_ctrl
    import filter_pkg::*;
#(
    parameter int PRECISION = KERNEL_PRECISION,
    parameter int COEFF_W   = 4
) (
    input  logic                                            VGA_CLK,
    input  logic                                            reset,
    input  logic                                            iVGA_VS,
    input  logic                                            step,
    input  logic                                            wr_en,
    input  logic signed [COEFF_W-1:0]                       coeff_in,
    input  logic                                            clear,
    input  logic                                            commit_req,
    input  logic [3:0]                                      mode_in,
    output logic signed [KDIM-1:0][KDIM-1:0][PRECISION-1:0] kernel,
    output logic [3:0]                                      mode,
    output logic [1:0]                                      cur_x,
    output logic [1:0]                                      cur_y,
    output logic                                            pending,
    output logic                                            commit_ack,
    output logic                                            rejected
);

    function automatic logic signed [KDIM-1:0][KDIM-1:0][PRECISION-1:0] identity_bank();
        logic signed [KDIM-1:0][KDIM-1:0][PRECISION-1:0] b;
        for (int r = 0; r < KDIM; r++)
            for (int c = 0; c < KDIM; c++)
                b[r][c] = IDENTITY_MASK[r][c] ? PRECISION'(1) : '0;
        return b;
    endfunction

    bank_state_e state, state_nxt;

    logic signed [KDIM-1:0][KDIM-1:0][PRECISION-1:0] shadow;
    logic [3:0]                                      shadow_mode;
    logic signed [PRECISION-1:0]                     coeff_ext;
    logic                                            vs_fall;
    logic                                            busy;

    vsync_edge u_vsync_edge (
        .VGA_CLK (VGA_CLK),
        .reset   (reset),
        .vs      (iVGA_VS),
        .fall    (vs_fall)
    );

    assign coeff_ext = PRECISION'(coeff_in);
    // While a swap is outstanding the shadow is frozen so the committed
    // contents are exactly what was there at commit time.
    assign busy      = (state != IDLE);

    always_ff @(posedge VGA_CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // A VS fall in IDLE is ignored, including one coincident with
    // commit_req: the swap then waits for the following frame boundary.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (commit_req) state_nxt = PENDING;
            PENDING: if (vs_fall)    state_nxt = SWAP;
            SWAP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Cursor: step is honoured in every state.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            cur_x <= 2'd0;
            cur_y <= 2'd0;
        end else if (step) begin
            if (cur_x == 2'd2) begin
                cur_x <= 2'd0;
                cur_y <= (cur_y == 2'd2) ? 2'd0 : cur_y + 2'd1;
            end else begin
                cur_x <= cur_x + 2'd1;
            end
        end
    end

    // Shadow bank: the write uses the pre-step cursor; clear wins over wr_en.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            shadow      <= identity_bank();
            shadow_mode <= 4'd0;
        end else if (!busy) begin
            if (clear)      shadow <= identity_bank();
            else if (wr_en) shadow[cur_y][cur_x] <= coeff_ext;
            if (commit_req) shadow_mode <= mode_in;
        end
    end

    // Active bank and status outputs, all registered.
    always_ff @(posedge VGA_CLK) begin
        if (reset) begin
            kernel     <= identity_bank();
            mode       <= 4'd0;
            pending    <= 1'b0;
            commit_ack <= 1'b0;
            rejected   <= 1'b0;
        end else begin
            if (state == SWAP) begin
                kernel <= shadow;
                mode   <= shadow_mode;
            end
            commit_ack <= (state == SWAP);
            pending    <= (state_nxt != IDLE);
            rejected   <= busy & (wr_en | clear | commit_req);
        end
    end

endmodule
